// File: rtl/vigna_bus_arbiter.sv
// Arbiter that merges the vigna instruction-fetch and data ports onto one valid/ready memory port.
// Defining VIGNA_ARB_TIMEOUT_EN adds a slave-response watchdog that drives bus_err.
module vigna_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int D_MAX_CONSEC   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [31:0]       d_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic              grant_d,
    output logic              bus_err
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int            SW         = (D_MAX_CONSEC < 1) ? 1 : $clog2(D_MAX_CONSEC + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(D_MAX_CONSEC);
    localparam bit            STARVE_EN  = (D_MAX_CONSEC != 0);

    state_t              state_reg, state_next;
    logic                mem_valid_reg, mem_valid_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [31:0]         mem_wdata_reg, mem_wdata_next;
    logic [3:0]          mem_wstrb_reg, mem_wstrb_next;
    logic                grant_d_reg, grant_d_next;
    logic [31:0]         i_rdata_reg, i_rdata_next;
    logic [31:0]         d_rdata_reg, d_rdata_next;
    logic                i_ready_reg, i_ready_next;
    logic                d_ready_reg, d_ready_next;
    logic [SW-1:0]       starve_reg, starve_next;
    logic                pick_d;

`ifdef VIGNA_ARB_TIMEOUT_EN
    localparam int            TW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          bus_err_reg, bus_err_next;
`endif

    // d wins unless i has watched D_MAX_CONSEC d grants go by while waiting.
    assign pick_d = d_valid && !(i_valid && STARVE_EN && (starve_reg == STARVE_MAX));

    always_comb begin
        state_next     = state_reg;
        mem_valid_next = mem_valid_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        grant_d_next   = grant_d_reg;
        i_rdata_next   = i_rdata_reg;
        d_rdata_next   = d_rdata_reg;
        starve_next    = starve_reg;
        i_ready_next   = 1'b0;
        d_ready_next   = 1'b0;
`ifdef VIGNA_ARB_TIMEOUT_EN
        to_cnt_next    = to_cnt_reg;
        bus_err_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (i_valid || d_valid) begin
                    state_next     = BUSY;
                    mem_valid_next = 1'b1;
                    grant_d_next   = pick_d;
`ifdef VIGNA_ARB_TIMEOUT_EN
                    to_cnt_next    = '0;
`endif
                    if (pick_d) begin
                        mem_addr_next  = d_addr;
                        mem_wdata_next = d_wdata;
                        mem_wstrb_next = d_wstrb;
                        if (i_valid && (starve_reg != STARVE_MAX)) begin
                            starve_next = starve_reg + 1'b1;
                        end
                    end else begin
                        mem_addr_next  = i_addr;
                        mem_wdata_next = '0;
                        mem_wstrb_next = '0;
                        starve_next    = '0;
                    end
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_next     = DONE;
                    mem_valid_next = 1'b0;
                    if (grant_d_reg) begin
                        d_rdata_next = mem_rdata;
                        d_ready_next = 1'b1;
                    end else begin
                        i_rdata_next = mem_rdata;
                        i_ready_next = 1'b1;
                    end
                end
`ifdef VIGNA_ARB_TIMEOUT_EN
                // A response arriving on the limit cycle is taken above, so it beats the abort.
                else if (to_cnt_reg == TO_LAST) begin
                    state_next     = DONE;
                    mem_valid_next = 1'b0;
                    bus_err_next   = 1'b1;
                    if (grant_d_reg) begin
                        d_rdata_next = 32'hDEAD_BEEF;
                        d_ready_next = 1'b1;
                    end else begin
                        i_rdata_next = 32'hDEAD_BEEF;
                        i_ready_next = 1'b1;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
`endif
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            mem_valid_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
            grant_d_reg   <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
            i_ready_reg   <= 1'b0;
            d_ready_reg   <= 1'b0;
            starve_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            mem_valid_reg <= mem_valid_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
            grant_d_reg   <= grant_d_next;
            i_rdata_reg   <= i_rdata_next;
            d_rdata_reg   <= d_rdata_next;
            i_ready_reg   <= i_ready_next;
            d_ready_reg   <= d_ready_next;
            starve_reg    <= starve_next;
        end
    end

`ifdef VIGNA_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_reg  <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            to_cnt_reg  <= to_cnt_next;
            bus_err_reg <= bus_err_next;
        end
    end

    assign bus_err = bus_err_reg;
`else
    // No watchdog: BUSY waits on the slave for as long as it takes.
    if (TIMEOUT_CYCLES >= 0) begin : g_no_timeout
        assign bus_err = 1'b0;
    end else begin : g_no_timeout_neg
        assign bus_err = 1'b0;
    end
`endif

    assign mem_valid = mem_valid_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign grant_d   = grant_d_reg;
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign i_ready   = i_ready_reg;
    assign d_ready   = d_ready_reg;

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Scoreboard bench for vigna_bus_arbiter: directed masters push expected grants, a negedge monitor checks them.
module tb_vigna_bus_arbiter;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_ready;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [31:0]       i_rdata;
    logic              d_valid = 1'b0;
    logic              d_ready;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [31:0]       d_wdata = '0;
    logic [3:0]        d_wstrb = '0;
    logic [31:0]       d_rdata;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata = '0;
    logic              grant_d;
    logic              bus_err;

    vigna_bus_arbiter #(
        .ADDR_W(ADDR_W), .D_MAX_CONSEC(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .grant_d(grant_d), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    bit   prev_mv = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    int   slave_delay = 1;
    bit   slave_mute = 1'b0;
    int   slave_cnt = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void bad(input string name, input logic [31:0] info);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got event (info %h) expected none", name, info);
    endfunction

    task automatic push_exp(input logic is_d, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_d = is_d; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    // Slave: answers with addr ^ A5A50000 (0x00A00093 for address 0x10) after slave_delay cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                mem_ready = 1'b0;
                slave_cnt = 0;
            end else if (mem_valid && !slave_mute) begin
                slave_cnt++;
                if (slave_cnt >= slave_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = (mem_addr == 32'h10) ? 32'h00A0_0093 : (mem_addr ^ 32'hA5A5_0000);
                    slave_cnt = 0;
                end
            end else begin
                slave_cnt = 0;
            end
        end
    end

    // Monitor: checks each grant against the queue head, holds it while BUSY, then checks the ready pulse.
    always @(negedge clk) begin
        if (reset) begin
            cur_valid = 1'b0;
            exp_q.delete();
            prev_mv = 1'b0;
        end else begin
            if (mem_valid && !prev_mv) begin
                if (exp_q.size() == 0) begin
                    bad("unexpected_grant", mem_addr);
                end else begin
                    cur = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("grant_d", 32'(grant_d), 32'(cur.is_d));
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_wdata", mem_wdata, cur.wdata);
                    check("mem_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
                end
            end else if (mem_valid && cur_valid) begin
                check("hold_addr", mem_addr, cur.addr);
                check("hold_wdata", mem_wdata, cur.wdata);
                check("hold_wstrb", 32'(mem_wstrb), 32'(cur.wstrb));
            end
            if (i_ready || d_ready) begin
                if (!cur_valid) begin
                    bad("unexpected_ready", {30'd0, i_ready, d_ready});
                end else begin
                    check("ready_sel", {30'd0, i_ready, d_ready}, cur.is_d ? 32'd1 : 32'd2);
                    check("rdata", cur.is_d ? d_rdata : i_rdata, cur.rdata);
                    check("bus_err", 32'(bus_err), 32'(cur.err));
                    $display("txn %s addr=%h wstrb=%h rdata=%h err=%0d", cur.is_d ? "D" : "I",
                             cur.addr, cur.wstrb, cur.is_d ? d_rdata : i_rdata, bus_err);
                    cur_valid = 1'b0;
                end
            end else if (bus_err) begin
                bad("stray_bus_err", 32'd1);
            end
            prev_mv = mem_valid;
        end
    end

    task automatic wait_ready(input bit is_d);
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (is_d ? d_ready : i_ready) got = 1'b1;
        end
        if (!got) bad(is_d ? "d_ready_timeout" : "i_ready_timeout", 32'd100);
    endtask

    // Called at posedge+1; returns at posedge+1 after the ready pulse.
    task automatic d_req(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws, input bit keep);
        d_valid = 1'b1; d_addr = addr; d_wdata = wd; d_wstrb = ws;
        wait_ready(1'b1);
        @(posedge clk);
        #1;
        if (!keep) d_valid = 1'b0;
    endtask

    task automatic i_req(input logic [31:0] addr);
        i_valid = 1'b1; i_addr = addr;
        wait_ready(1'b0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_mem_valid();
        bit got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (mem_valid) got = 1'b1;
        end
        if (!got) bad("mem_valid_timeout", 32'd50);
    endtask

    logic [31:0] st_addr [6] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
    logic [31:0] st_wd   [6] = '{32'h1, 32'h0, 32'h3, 32'h0, 32'h0, 32'h6};
    logic [3:0]  st_ws   [6] = '{4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'hC};

    initial begin
        int busy_n;
        // Reset state, both while held and after release.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_readys", {30'd0, i_ready, d_ready}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_mem_addr", mem_addr, 32'd0);
        check("idle_rdata", i_rdata | d_rdata, 32'd0);
        check("idle_grant_err", {30'd0, grant_d, bus_err}, 32'd0);

        // Instruction fetch only, slave answers after 2 cycles.
        @(posedge clk);
        #1;
        slave_delay = 2;
        push_exp(1'b0, 32'h10, 32'h0, 4'h0, 32'h00A0_0093, 1'b0);
        i_valid = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check("lat_before", 32'(mem_valid), 32'd0);
        @(negedge clk);
        check("lat_grant", 32'(mem_valid), 32'd1);
        wait_ready(1'b0);
        @(posedge clk);
        #1 i_valid = 1'b0;

        // Data write, then data read.
        slave_delay = 3;
        push_exp(1'b1, 32'h0, 32'd10, 4'hF, 32'hA5A5_0000, 1'b0);
        d_req(32'h0, 32'd10, 4'hF, 1'b0);
        slave_delay = 1;
        push_exp(1'b1, 32'h24, 32'h0, 4'h0, 32'hA5A5_0024, 1'b0);
        d_req(32'h24, 32'h0, 4'h0, 1'b0);

        // Simultaneous requests: d first, then i.
        slave_delay = 2;
        push_exp(1'b1, 32'h8, 32'h1234, 4'h3, 32'hA5A5_0008, 1'b0);
        push_exp(1'b0, 32'h40, 32'h0, 4'h0, 32'hA5A5_0040, 1'b0);
        fork
            d_req(32'h8, 32'h1234, 4'h3, 1'b0);
            i_req(32'h40);
        join

        // Stray mem_ready while idle is ignored; rdata outputs hold.
        @(negedge clk);
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk);
            check("stray_quiet", {29'd0, mem_valid, i_ready, d_ready}, 32'd0);
        end
        check("hold_i_rdata", i_rdata, 32'hA5A5_0040);
        check("hold_d_rdata", d_rdata, 32'hA5A5_0008);
        @(posedge clk);
        #1;

        // Starvation: i waits through 4 d grants, then wins once.
        slave_delay = 1;
        for (int k = 0; k < 4; k++) push_exp(1'b1, st_addr[k], st_wd[k], st_ws[k], st_addr[k] ^ 32'hA5A5_0000, 1'b0);
        push_exp(1'b0, 32'h80, 32'h0, 4'h0, 32'hA5A5_0080, 1'b0);
        for (int k = 4; k < 6; k++) push_exp(1'b1, st_addr[k], st_wd[k], st_ws[k], st_addr[k] ^ 32'hA5A5_0000, 1'b0);
        fork
            begin
                for (int k = 0; k < 6; k++) d_req(st_addr[k], st_wd[k], st_ws[k], k < 5);
            end
            i_req(32'h80);
        join

        // Reset during BUSY drops the transaction.
        slave_mute = 1'b1;
        push_exp(1'b1, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0);
        d_valid = 1'b1; d_addr = 32'h30; d_wdata = 32'h0; d_wstrb = 4'h0;
        wait_mem_valid();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstb_mem_valid", 32'(mem_valid), 32'd0);
        check("rstb_mem_addr", mem_addr, 32'd0);
        check("rstb_d_rdata", d_rdata, 32'd0);
        check("rstb_i_rdata", i_rdata, 32'd0);
        check("rstb_flags", {28'd0, grant_d, i_ready, d_ready, bus_err}, 32'd0);
        d_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        slave_mute = 1'b0;
        @(posedge clk);
        #1;
        push_exp(1'b1, 32'h34, 32'h0, 4'h0, 32'hA5A5_0034, 1'b0);
        d_req(32'h34, 32'h0, 4'h0, 1'b0);

        // Slave that never answers.
        slave_mute = 1'b1;
`ifdef VIGNA_ARB_TIMEOUT_EN
        push_exp(1'b1, 32'h50, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        d_valid = 1'b1; d_addr = 32'h50; d_wstrb = 4'h0;
        wait_mem_valid();
        busy_n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!mem_valid) break;
            busy_n++;
        end
        check("timeout_busy_cycles", busy_n, 32'd8);
        @(posedge clk);
        #1 d_valid = 1'b0;
        slave_mute = 1'b0;
`else
        push_exp(1'b1, 32'h50, 32'h0, 4'h0, 32'h0, 1'b0);
        d_valid = 1'b1; d_addr = 32'h50; d_wstrb = 4'h0;
        wait_mem_valid();
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_valid && !bus_err) busy_n++;
        end
        check("no_timeout_wait", busy_n, 32'd20);
        @(posedge clk);
        #1 reset = 1'b1;
        d_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        slave_mute = 1'b0;
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size() + 32'(cur_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vigna_bus_arbiter.md
Name: vigna_bus_arbiter

Overview:
Two-master to one-slave arbiter that merges the vigna core's instruction port (read-only) and data port (read/write) onto a single unified memory port. It uses the same valid/ready protocol on all three sides. It sits between the core and a single-ported RAM or system bus in unified-memory configurations. The data port has priority by default, with a bounded-starvation guarantee for instruction fetch.

Parameters:
ADDR_W, 32, address width on all ports
D_MAX_CONSEC, 4, max consecutive d grants while i is waiting before i is forced; 0 means pure d priority
TIMEOUT_CYCLES, 255, slave response limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_valid  in  1  instruction fetch request
i_ready  out  1  one-cycle completion pulse to instruction master
i_addr  in  ADDR_W  fetch address
i_rdata  out  32  fetch data, valid while i_ready=1
d_valid  in  1  data request
d_ready  out  1  one-cycle completion pulse to data master
d_addr  in  ADDR_W  data address
d_wdata  in  32  store data
d_wstrb  in  4  byte strobes; 0 = read
d_rdata  out  32  load data, valid while d_ready=1
mem_valid  out  1  request to slave
mem_ready  in  1  slave completion pulse
mem_addr  out  ADDR_W  latched request address
mem_wdata  out  32  latched store data (0 for i grants)
mem_wstrb  out  4  latched strobes (0 for i grants)
mem_rdata  in  32  slave read data, sampled when mem_ready=1
grant_d  out  1  1 while the current or last transaction belongs to d
bus_err  out  1  timeout pulse; constant 0 when the feature is absent

Behaviour:
- Reset (async, reset=1): state=IDLE. All outputs 0. Starvation counter 0. Timeout counter 0.
- States: IDLE, BUSY, DONE.
- IDLE, grant rules:
  - Only d_valid → grant d.
  - Only i_valid → grant i.
  - Both → grant d, unless the starvation counter == D_MAX_CONSEC and D_MAX_CONSEC != 0; then grant i.
- Grant action: latch the winner's addr/wdata/wstrb into mem_* (i grant: wdata=0, wstrb=0). Set grant_d. Register mem_valid=1 and go to BUSY. mem_valid rises the cycle after the request is seen in IDLE.
- Starvation counter:
  - Increments on a d grant while i_valid=1, saturating at D_MAX_CONSEC.
  - Clears on any i grant.
  - Holds on a d grant with i_valid=0.
- BUSY: mem_valid=1 and mem_* held stable until mem_ready=1. On mem_ready:
  - Capture mem_rdata into i_rdata or d_rdata per grant_d.
  - Drop mem_valid.
  - Go to DONE.
- DONE, one cycle only:
  - The granted master's ready=1 (registered); the other master's ready stays 0.
  - No new grant is issued.
  - Return to IDLE.
- Latency: request-to-mem_valid 1 cycle; mem_ready-to-master-ready 1 cycle. Minimum 3-cycle issue interval.
- Master obligation: deassert valid in the cycle after its ready pulse. A valid still high when IDLE is re-entered is treated as a new request.
- The master not granted is never acknowledged; its request waits unchanged.
- rdata outputs hold their last value after the ready pulse. Write transactions also capture mem_rdata.
- mem_ready outside BUSY is ignored.
- Reset asserted mid-transaction: immediate return to the reset state. The pending transaction is dropped with no ready pulse.

Optional Feature:
Macro: VIGNA_ARB_TIMEOUT_EN.
- Defined:
  - The timeout counter clears on entering BUSY and increments each BUSY cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES: drop mem_valid, load 32'hDEADBEEF into the granted master's rdata, and go to DONE.
  - DONE then gives the normal ready pulse plus bus_err=1 for that same cycle.
  - A late mem_ready after the abort is ignored.
  - mem_ready in the same cycle the count is reached wins: normal completion, no error.
- Undefined: no counter is built; BUSY waits indefinitely; bus_err is tied to 0.

Test Plan:
- i only: i_addr=0x10, slave returns 0x00A00093 after 2 cycles → mem_valid 1 cycle after request, mem_wstrb=0, i_ready single pulse with i_rdata=0x00A00093, d_ready stays 0.
- d write: d_addr=0x0, d_wdata=10, d_wstrb=4'hF → mem_addr=0, mem_wdata=10, mem_wstrb=F held until mem_ready, then d_ready pulse, grant_d=1.
- Simultaneous i and d requests in IDLE → d served first, then i served on the next IDLE; mem_* never change while mem_valid=1.
- Starvation: i_valid held high, d issues 6 back-to-back requests, D_MAX_CONSEC=4 → grant order d,d,d,d,i,d,d.
- Reset raised while in BUSY → all outputs 0 immediately; no ready pulse; after release a fresh request completes normally.
- With VIGNA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never answers → mem_valid drops after 8 BUSY cycles; d_ready and bus_err pulse together with d_rdata=0xDEADBEEF. Without the macro, bus_err stays 0 and mem_valid stays high.
